priority_encoder_8to3: RTL and testbench

PRIORITY_ENCODER_8TO3 -- requirements
Module: priority_encoder_8to3

---
 rtl/priority_encoder_8to3.sv | 121 ++++++++++++
 tb/tb_priority_encoder_8to3.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_8to3.sv
// priority_encoder_8to3
// Eight level request lines are collected into a pending register and served
// one at a time as a 3-bit code with a valid/ready handshake. A served bit is
// removed from the pending set on the edge it is issued, unless the same
// request line is high on that edge; the new request then keeps the bit set.
// Selection looks only at the registered pending set, so a new request
// appears on code no sooner than one edge after it is sampled.
//
// Configuration macro:
//   ROUND_ROBIN_EN  when defined, the search starts one index past the last
//                   issued code and wraps 7 -> 0. The pointer resets to 7, so
//                   the first search after reset starts at index 0. When the
//                   macro is undefined, the lowest set index wins and the
//                   design has no pointer register.

module priority_encoder_8to3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] code,
  output logic [3:0] pend_cnt,
  output logic       merged
);

  // Number of set bits in an 8-bit vector (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

`ifdef ROUND_ROBIN_EN
  // First set bit found by searching from last+1 upward, wrapping 7 -> 0.
  // The loop runs from the farthest candidate down to the nearest one, so
  // the nearest set bit makes the final assignment.
  function automatic logic [2:0] rr_index(input logic [7:0] v,
                                          input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] cand;
    idx = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      cand = last + 3'(k);
      if (v[cand]) idx = cand;
    end
    return idx;
  endfunction
`else
  // Lowest set index; scanning downward leaves the lowest one assigned last.
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction
`endif

  logic [7:0] pend_p0;
  logic       issue;
  logic [2:0] sel;
  logic [7:0] issue_mask;
  logic [7:0] pend_next;
  logic       merge_hit;

`ifdef ROUND_ROBIN_EN
  logic [2:0] last_p0;
`endif

  // Stage 0 -> 1: choose the next code from the registered pending set and
  // form the pending set for the following cycle.
  always_comb begin
    issue = (pend_p0 != 8'd0) && (!valid || ready);
`ifdef ROUND_ROBIN_EN
    sel = rr_index(pend_p0, last_p0);
`else
    sel = lowest_index(pend_p0);
`endif
    issue_mask = issue ? (8'd1 << sel) : 8'd0;
    pend_next  = (pend_p0 & ~issue_mask) | req;
    merge_hit  = |(req & pend_p0 & ~issue_mask);
  end

  // Pending set, handshake outputs and the sticky merge flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_p0  <= 8'd0;
      valid    <= 1'b0;
      code     <= 3'd0;
      pend_cnt <= 4'd0;
      merged   <= 1'b0;
    end else begin
      pend_p0  <= pend_next;
      pend_cnt <= popcount8(pend_next);
      if (merge_hit) merged <= 1'b1;
      if (issue) begin
        valid <= 1'b1;
        code  <= sel;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef ROUND_ROBIN_EN
  // Round-robin pointer: remembers the most recently issued index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_p0 <= 3'd7;
    end else if (issue) begin
      last_p0 <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// tb_priority_encoder_8to3
// Bench for priority_encoder_8to3. Directed scenarios use hand-computed
// constants; the randomized scenario compares against a request-level model
// that tracks each pending line as a separate flag. Define ROUND_ROBIN_EN
// for both bench and design to exercise the round-robin build.

module tb_priority_encoder_8to3;

`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] code;
  logic [3:0] pend_cnt;
  logic       merged;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit m_pend[8];
  bit m_valid;
  int m_code;
  int m_last;
  bit m_merged;
  int m_cnt;

  priority_encoder_8to3 dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ready    (ready),
    .valid    (valid),
    .code     (code),
    .pend_cnt (pend_cnt),
    .merged   (merged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_valid  = 1'b0;
    m_code   = 0;
    m_last   = 7;
    m_merged = 1'b0;
    m_cnt    = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    bit old[8];
    bit any;
    int hit;
    old = m_pend;
    any = 1'b0;
    hit = -1;
    for (int i = 0; i < 8; i++) if (old[i]) any = 1'b1;
    if (any && (!m_valid || ready)) begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = RR ? (m_last + 1 + k) % 8 : k;
        if (hit < 0 && old[idx]) hit = idx;
      end
    end
    if (hit >= 0) begin
      m_valid = 1'b1;
      m_code  = hit;
      m_last  = hit;
      m_pend[hit] = 1'b0;
    end else if (ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (req[i] && old[i] && i != hit) m_merged = 1'b1;
      if (req[i]) m_pend[i] = 1'b1;
    end
    m_cnt = 0;
    for (int i = 0; i < 8; i++) m_cnt += int'(m_pend[i]);
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 8'hA5; ready = 1'b1;
    do_reset();
    req = 8'd0;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid); end
    n_tests++; if (code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", code); end
    n_tests++; if (pend_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_pend got %0d want 0", pend_cnt); end
    n_tests++; if (merged !== 1'b0) begin n_fail++; $display("FAIL reset_merged got %0b want 0", merged); end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'b0000_0100; ready = 1'b1;
    cycle();
    req = 8'd0;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_valid got %0b want 0", valid); end
    cycle();
    n_tests++; if (valid !== 1'b1 || code !== 3'd2) begin n_fail++; $display("FAIL single_issue got v=%0b c=%0d want v=1 c=2", valid, code); end
    cycle();
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_clear got %0b want 0", valid); end
  endtask

  task automatic test_two();
    do_reset();
    req = 8'b1000_0001; ready = 1'b1;
    cycle();
    req = 8'd0;
    cycle();
    n_tests++; if (valid !== 1'b1 || code !== 3'd0 || pend_cnt !== 4'd1) begin n_fail++; $display("FAIL two_first got v=%0b c=%0d p=%0d want 1/0/1", valid, code, pend_cnt); end
    cycle();
    n_tests++; if (valid !== 1'b1 || code !== 3'd7 || pend_cnt !== 4'd0) begin n_fail++; $display("FAIL two_second got v=%0b c=%0d p=%0d want 1/7/0", valid, code, pend_cnt); end
  endtask

  task automatic test_hold();
    do_reset();
    req = 8'b0001_0010; ready = 1'b0;
    cycle();
    req = 8'd0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_tests++; if (valid !== 1'b1 || code !== 3'd1 || pend_cnt !== 4'd1) begin n_fail++; $display("FAIL hold_%0d got v=%0b c=%0d p=%0d want 1/1/1", k, valid, code, pend_cnt); end
    end
    ready = 1'b1;
    cycle();
    n_tests++; if (valid !== 1'b1 || code !== 3'd4 || pend_cnt !== 4'd0) begin n_fail++; $display("FAIL hold_release got v=%0b c=%0d p=%0d want 1/4/0", valid, code, pend_cnt); end
    cycle();
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL hold_drain got %0b want 0", valid); end
  endtask

  task automatic test_merged();
    do_reset();
    req = 8'b0000_1000; ready = 1'b0;
    cycle();
    cycle();
    n_tests++; if (merged !== 1'b0) begin n_fail++; $display("FAIL merged_early got %0b want 0", merged); end
    cycle();
    n_tests++; if (merged !== 1'b1) begin n_fail++; $display("FAIL merged_set got %0b want 1", merged); end
    req = 8'd0; ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    n_tests++; if (merged !== 1'b1) begin n_fail++; $display("FAIL merged_sticky got %0b want 1", merged); end
    do_reset();
    n_tests++; if (merged !== 1'b0) begin n_fail++; $display("FAIL merged_reset got %0b want 0", merged); end
  endtask

  task automatic test_round_robin();
    int want;
    do_reset();
    req = 8'hFF; ready = 1'b1;
    cycle();
    for (int k = 0; k < 9; k++) begin
      cycle();
      want = RR ? (k % 8) : 0;
      n_tests++; if (valid !== 1'b1 || int'(code) != want) begin n_fail++; $display("FAIL rr_seq_%0d got v=%0b c=%0d want v=1 c=%0d", k, valid, code, want); end
    end
    req = 8'd0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'b0001_1110; ready = 1'b0;
    cycle();
    req = 8'd0;
    cycle();
    n_tests++; if (valid !== 1'b1 || code !== 3'd1 || pend_cnt !== 4'd3) begin n_fail++; $display("FAIL mid_pre got v=%0b c=%0d p=%0d want 1/1/3", valid, code, pend_cnt); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (valid !== 1'b0 || code !== 3'd0 || pend_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_async got v=%0b c=%0d p=%0d want 0/0/0", valid, code, pend_cnt); end
    req = 8'hFF; ready = 1'b1;
    @(posedge clk);
    #2;
    req = 8'd0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_tests++; if (valid !== 1'b0 || pend_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_after_%0d got v=%0b p=%0d want 0/0", k, valid, pend_cnt); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
      ready = ($urandom_range(0, 2) != 0);
      cycle();
      n_tests++; if (valid !== m_valid) begin n_fail++; $display("FAIL rand_valid_%0d got %0b want %0b", k, valid, m_valid); end
      n_tests++; if (int'(code) != m_code) begin n_fail++; $display("FAIL rand_code_%0d got %0d want %0d", k, code, m_code); end
      n_tests++; if (int'(pend_cnt) != m_cnt) begin n_fail++; $display("FAIL rand_pend_%0d got %0d want %0d", k, pend_cnt, m_cnt); end
      n_tests++; if (merged !== m_merged) begin n_fail++; $display("FAIL rand_merged_%0d got %0b want %0b", k, merged, m_merged); end
    end
    req = 8'd0;
  endtask

  initial begin
    rst = 1'b1; req = 8'd0; ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_two();
    test_hold();
    test_merged();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
